// File: rtl/pwm_pkg.sv
// Shared constants and the per-pin drive decode for the PWM output block.
// No ports; imported by pwm_timebase and pwm_peripheral.
package pwm_pkg;

   localparam int unsigned PWM_CNT_W = 8;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam int unsigned NUM_PINS = 16;

   typedef enum logic [1:0] {
      PIN_OFF,
      PIN_ON,
      PIN_PWM
   } pin_mode_e;

   // Output enable dominates; mode only matters for an enabled pin.
   function automatic pin_mode_e decode_pin(input logic en, input logic pwm_mode);
      if (!en) begin
         return PIN_OFF;
      end else if (!pwm_mode) begin
         return PIN_ON;
      end else begin
         return PIN_PWM;
      end
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, free-running 8-bit period counter, duty
// shadow register and period-start strobe.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   duty         live duty-cycle value from the register bank
//   pwm_hi       compare result for the current counter step (combinational)
//   period_start one-clk strobe, high in the first cycle of each period
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned CLK_DIV = 3000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PWM_CNT_W-1:0] duty,
   output logic                 pwm_hi,
   output logic                 period_start
);

   localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

   logic [PRESC_W-1:0]   prescaler_q, prescaler_d;
   logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_CNT_W-1:0] duty_shadow_q, duty_shadow_d;
   logic                 period_start_q, period_start_d;
   logic                 tick;
   logic                 wrap;

   assign tick = (prescaler_q == PRESC_MAX);
   assign wrap = tick && (pwm_cnt_q == {PWM_CNT_W{1'b1}});

   always_comb begin
      prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
      pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
      // Duty only updates on the period boundary so a period is never split.
      duty_shadow_d  = wrap ? duty : duty_shadow_q;
      period_start_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler_q    <= '0;
         pwm_cnt_q      <= '0;
         duty_shadow_q  <= '0;
         period_start_q <= 1'b0;
      end else begin
         prescaler_q    <= prescaler_d;
         pwm_cnt_q      <= pwm_cnt_d;
         duty_shadow_q  <= duty_shadow_d;
         period_start_q <= period_start_d;
      end
   end

   // 0xFF is forced to full-on; the plain compare would leave one step low.
   assign pwm_hi       = (duty_shadow_q == DUTY_FULL) ? 1'b1 : (pwm_cnt_q < duty_shadow_q);
   assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage. Each pin is driven low, high, or from the shared
// PWM compare, selected by the SPI register bank; the pin drive is registered.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   EN_OUT_7_0/15_8       per-pin output enable
//   EN_PWM_MODE_7_0/15_8  per-pin PWM mode select
//   PWM_DUTY_CYCLE_7_0    shared duty cycle (0xFF = always high)
//   pwm_out               pin drive
//   period_start          one-clk strobe at each PWM period start
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int unsigned CLK_DIV = 3000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          EN_OUT_7_0,
   input  logic [7:0]          EN_OUT_15_8,
   input  logic [7:0]          EN_PWM_MODE_7_0,
   input  logic [7:0]          EN_PWM_MODE_15_8,
   input  logic [7:0]          PWM_DUTY_CYCLE_7_0,
   output logic [NUM_PINS-1:0] pwm_out,
   output logic                period_start
);

   logic                pwm_hi;
   logic [NUM_PINS-1:0] en;
   logic [NUM_PINS-1:0] mode;
   logic [NUM_PINS-1:0] pwm_out_d, pwm_out_q;

   assign en   = {EN_OUT_15_8, EN_OUT_7_0};
   assign mode = {EN_PWM_MODE_15_8, EN_PWM_MODE_7_0};

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .duty         (PWM_DUTY_CYCLE_7_0),
      .pwm_hi       (pwm_hi),
      .period_start (period_start)
   );

   always_comb begin
      pwm_out_d = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         unique case (decode_pin(en[i], mode[i]))
            PIN_OFF: pwm_out_d[i] = 1'b0;
            PIN_ON:  pwm_out_d[i] = 1'b1;
            PIN_PWM: pwm_out_d[i] = pwm_hi;
            default: pwm_out_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_out_q <= '0;
      end else begin
         pwm_out_q <= pwm_out_d;
      end
   end

   assign pwm_out = pwm_out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (CLK_DIV=4 and CLK_DIV=1) share
// inputs and reset; an arithmetic model derived from cycles-since-reset
// predicts every pin and strobe each cycle, alongside directed measurements.
module tb_pwm_peripheral;

   logic        clk;
   logic        rst_n;
   logic [15:0] en;
   logic [15:0] mode;
   logic [7:0]  duty;
   logic [15:0] out4, out1;
   logic        ps4, ps1;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   pwm_peripheral #(
      .CLK_DIV (4)
   ) dut4 (
      .clk                (clk),
      .rst_n              (rst_n),
      .EN_OUT_7_0         (en[7:0]),
      .EN_OUT_15_8        (en[15:8]),
      .EN_PWM_MODE_7_0    (mode[7:0]),
      .EN_PWM_MODE_15_8   (mode[15:8]),
      .PWM_DUTY_CYCLE_7_0 (duty),
      .pwm_out            (out4),
      .period_start       (ps4)
   );

   pwm_peripheral #(
      .CLK_DIV (1)
   ) dut1 (
      .clk                (clk),
      .rst_n              (rst_n),
      .EN_OUT_7_0         (en[7:0]),
      .EN_OUT_15_8        (en[15:8]),
      .EN_PWM_MODE_7_0    (mode[7:0]),
      .EN_PWM_MODE_15_8   (mode[15:8]),
      .PWM_DUTY_CYCLE_7_0 (duty),
      .pwm_out            (out1),
      .period_start       (ps1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // n = edges since reset; step = n/div; period length = 256*div edges.
   function automatic logic model_hi(input int n, input int div, input logic [7:0] sh);
      int step;
      step = (n / div) % 256;
      if (sh == 8'hFF) return 1'b1;
      return (step < int'(sh));
   endfunction

   function automatic logic [15:0] model_pins(input logic [15:0] e, input logic [15:0] m,
                                              input logic h);
      return e & (~m | {16{h}});
   endfunction

   int          n4, n1;
   logic [7:0]  sh4, sh1;
   logic [15:0] eo4, eo1;
   logic        ep4, ep1;

   always @(posedge clk) begin
      if (!rst_n) begin
         n4 <= 0; sh4 <= 8'h00; eo4 <= 16'h0; ep4 <= 1'b0;
         n1 <= 0; sh1 <= 8'h00; eo1 <= 16'h0; ep1 <= 1'b0;
      end else begin
         n4  <= n4 + 1;
         ep4 <= ((n4 + 1) % 1024) == 0;
         if (((n4 + 1) % 1024) == 0) sh4 <= duty;
         eo4 <= model_pins(en, mode, model_hi(n4, 4, sh4));
         n1  <= n1 + 1;
         ep1 <= ((n1 + 1) % 256) == 0;
         if (((n1 + 1) % 256) == 0) sh1 <= duty;
         eo1 <= model_pins(en, mode, model_hi(n1, 1, sh1));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out4_model", out4, eo4);
         check("ps4_model", ps4, ep4);
         check("out1_model", out1, eo1);
         check("ps1_model", ps1, ep1);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_ps4();
      bit seen;
      seen = 0;
      for (int k = 0; k < 1100 && !seen; k++) begin
         @(negedge clk);
         if (ps4) seen = 1;
      end
      if (!seen) check("ps4_timeout", 0, 1);
   endtask

   // Counts high cycles of one pin of the CLK_DIV=4 instance over a full period,
   // optionally changing duty after change_at cycles.
   task automatic measure(input int pin, input int change_at, input logic [7:0] new_duty,
                          output int hi_cnt);
      hi_cnt = 0;
      wait_ps4();
      for (int k = 0; k < 1024; k++) begin
         if (k == change_at) duty = new_duty;
         @(negedge clk);
         if (out4[pin]) hi_cnt++;
      end
   endtask

   initial begin
      int first4, first1, cnt, k;
      logic [7:0] sweep [4];

      sweep[0] = 8'h00; sweep[1] = 8'h40; sweep[2] = 8'h80; sweep[3] = 8'hFF;

      // Reset held with everything enabled.
      rst_n = 1'b0; en = 16'hFFFF; mode = 16'hFFFF; duty = 8'hFF;
      @(negedge clk);
      chk_en = 1;
      repeat (4) @(negedge clk);
      check("rst_out4", out4, 16'h0000);
      check("rst_ps4", ps4, 0);

      // Release: first period runs with duty_shadow 0, strobes at 256*div.
      rst_n = 1'b1;
      first4 = 0; first1 = 0;
      for (int j = 1; j <= 1100; j++) begin
         @(negedge clk);
         if (ps4 && first4 == 0) first4 = j;
         if (ps1 && first1 == 0) first1 = j;
         if (j == 500) check("first_period_low", out4, 16'h0000);
      end
      check("first_ps4_delay", first4, 1024);
      check("first_ps1_delay", first1, 256);

      // Static drive.
      en = 16'h0FA5; mode = 16'h0000;
      @(negedge clk);
      check("static_drive", out4, 16'h0FA5);
      repeat (2048) @(negedge clk);
      check("static_hold", out4, 16'h0FA5);
      en[7:0] = 8'h00;
      @(negedge clk);
      check("static_off_low", out4[7:0], 8'h00);

      // Duty sweep on all pins.
      en = 16'hFFFF; mode = 16'hFFFF;
      foreach (sweep[s]) begin
         duty = sweep[s];
         measure(0, -1, 8'h00, cnt);
         check($sformatf("sweep_%02h", sweep[s]), cnt,
               (sweep[s] == 8'hFF) ? 1024 : 4 * int'(sweep[s]));
      end

      // Mid-period duty change only lands at the next period.
      duty = 8'h20;
      wait_ps4();
      measure(3, 400, 8'hC0, cnt);
      check("shadow_cur_period", cnt, 32 * 4);
      measure(3, -1, 8'h00, cnt);
      check("shadow_next_period", cnt, 192 * 4);

      // Mixed modes.
      en = 16'hFFFF; mode = 16'h00F0; duty = 8'h80;
      wait_ps4();
      measure(4, -1, 8'h00, cnt);
      check("mixed_pwm_pin", cnt, 512);
      measure(0, -1, 8'h00, cnt);
      check("mixed_static_pin", cnt, 1024);
      en = 16'h0000; mode = 16'hFFFF;
      @(negedge clk);
      check("mode_no_enable", out4, 16'h0000);

      // Randomized enable/mode/duty traffic, checked by the model each cycle.
      for (int r = 0; r < 3000; r++) begin
         if ($urandom_range(0, 15) == 0) en = 16'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 16'($urandom);
         if ($urandom_range(0, 63) == 0) duty = 8'($urandom);
         @(negedge clk);
      end

      // Mid-run reset of the CLK_DIV=1 instance at pwm_cnt=77.
      en = 16'hFFFF; mode = 16'hFFFF; duty = 8'hFF;
      k = 0;
      while ((n1 % 256) != 77 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("reach_cnt77", int'((n1 % 256) == 77), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out1", out1, 16'h0000);
      check("midrst_ps1", ps1, 0);
      rst_n = 1'b1;
      first1 = 0;
      for (int j = 1; j <= 300; j++) begin
         @(negedge clk);
         if (ps1 && first1 == 0) first1 = j;
      end
      check("midrst_ps1_delay", first1, 256);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the register bank written over SPI (output enables, PWM-mode enables, duty cycle) and drives 16 output pins. Each pin is statically low, statically high, or PWM-modulated. One shared 8-bit PWM timebase is derived from clk by a programmable prescaler. The block sits directly downstream of the SPI register stage and feeds the top-level output pads.

Parameters:
CLK_DIV, 3000, system clocks per PWM counter step (legal range 1..65535); PWM frequency = f_clk / (CLK_DIV * 256)

Ports:
clk  input  1  system clock; sole clock domain
rst_n  input  1  reset, synchronous, active-low
EN_OUT_7_0  input  8  output enable, pins 7..0
EN_OUT_15_8  input  8  output enable, pins 15..8
EN_PWM_MODE_7_0  input  8  PWM mode select, pins 7..0
EN_PWM_MODE_15_8  input  8  PWM mode select, pins 15..8
PWM_DUTY_CYCLE_7_0  input  8  shared duty cycle; high time = duty/256 of period, 0xFF = 100%
pwm_out  output  16  pin drive
period_start  output  1  one-clk strobe at the start of each PWM period

Behaviour:
- Reset (rst_n low at posedge clk): prescaler=0, pwm_cnt=0, duty_shadow=0, pwm_out=16'h0000, period_start=0. Reset asserted mid-period forces these values on the next edge. After release, the counters restart from 0.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick=1 in the cycle where prescaler==CLK_DIV-1.
  - With CLK_DIV=1, tick is high every cycle.
  - Prescaler width is clog2(CLK_DIV), minimum 1 bit.
- pwm_cnt:
  - 8-bit, increments on tick, wraps 255->0. A period is 256 ticks.
  - Free-running; not gated by any enable.
- Duty shadow:
  - duty_shadow loads PWM_DUTY_CYCLE_7_0 only on the wrap (tick && pwm_cnt==255).
  - A duty change mid-period takes effect at the next period start. There is no partial-period glitch.
  - The first period after reset uses duty_shadow=0, so PWM pins stay low for the first 256 ticks.
- period_start: registered, high for exactly one clk in the cycle after the wrap tick (pwm_cnt becomes 0 in that same cycle).
- Compare: pwm_hi = 1 if duty_shadow==8'hFF, else (pwm_cnt < duty_shadow). 0x00 gives constant low; 0x80 gives 128/256 high.
- Per pin i, pwm_out[i] is registered from current-cycle values (1-clk latency):
  - EN_OUT[i]=0 -> 0, regardless of mode.
  - EN_OUT[i]=1, EN_PWM_MODE[i]=0 -> 1.
  - EN_OUT[i]=1, EN_PWM_MODE[i]=1 -> pwm_hi.
- Enable/mode changes reach the pin exactly 1 clk after the input changes. They are not period-aligned.
- All PWM-mode pins share one phase: rising edges coincide at period start.
- Inputs are in the clk domain already (produced by the SPI stage); no synchronizers.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8
  - DUTY_FULL=8'hFF
  - NUM_PINS=16
  - PIN_MODE enum {PIN_OFF, PIN_ON, PIN_PWM}, used for per-pin decode
- Sub-module pwm_timebase (parameter CLK_DIV):
  - Contains prescaler, pwm_cnt, duty_shadow, wrap detection, period_start.
  - Outputs pwm_hi and period_start.
- Top handles the 16-pin enable/mode mux and output registers.

Test Plan:
- Reset: hold rst_n=0 for 5 clks with all inputs 0xFF -> pwm_out=0, period_start=0 throughout. Release -> first period_start occurs after 256*CLK_DIV clks.
- Static drive (CLK_DIV=4): EN_OUT=0xA5/0x0F, PWM_MODE=0 -> one clk later pwm_out=16'h0FA5, constant over 2 periods. Set EN_OUT_7_0=0 -> pwm_out[7:0]=0 after 1 clk.
- Duty sweep (CLK_DIV=4, all pins EN_OUT=1, PWM_MODE=1):
  - duty 0x00 -> constant low.
  - duty 0x40 -> high for 64*4=256 clks per 1024-clk period.
  - duty 0x80 -> 512 high.
  - duty 0xFF -> constant high.
- Shadow timing: change duty 0x20->0xC0 at pwm_cnt=100 -> the current period keeps 32-tick high time; the next period (after period_start) has 192 ticks high.
- Mixed modes: EN_OUT=0xFFFF, PWM_MODE=0x00F0, duty=0x80 -> pins 7..4 toggle 50%, others constant 1. Mode bits set with EN_OUT=0 -> pin stays 0.
- CLK_DIV=1 and mid-run reset: period=256 clks, period_start every 256 clks. Assert rst_n=0 at pwm_cnt=77 -> next edge all outputs 0, counters 0.
